ovc_credit_scheduler: RTL and testbench

Credit-based output-VC scheduler that shares one router output flit link among V virtual channels. Keeps one credit counter per output VC, loaded from the neighbour's credit init value while reset is held. Grants one requesting VC per cycle by packet-level round-robin, and locks the link to a VC from header flit to tail flit. Sits between the per-VC output buffers and the flit channel driver of a ProNoC router output port.

---
 rtl/ovc_credit_scheduler_pkg.sv | 24 ++
 rtl/ovc_credit_scheduler_rr_arb.sv | 33 +++
 rtl/ovc_credit_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_ovc_credit_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ovc_credit_scheduler_pkg.sv
// ovc_credit_scheduler_pkg
// Shared types and sizes for the output-VC credit scheduler.
//   OVC_V / OVC_B : default VC count and neighbour buffer depth
//   CRDTw         : credit counter width, matches ctrl_chanel_t credit_init_val
//   ovc_sched_state_t  : link FSM state
//   ovc_sched_status_t : locked flag, one-hot locked VC, sticky error
package ovc_credit_scheduler_pkg;

  localparam int OVC_V = 4;
  localparam int OVC_B = 4;
  localparam int CRDTw = $clog2(OVC_B + 1);

  typedef enum logic {
    OSCH_IDLE   = 1'b0,
    OSCH_LOCKED = 1'b1
  } ovc_sched_state_t;

  typedef struct packed {
    logic             locked;
    logic [OVC_V-1:0] lock_vc;
    logic             err;
  } ovc_sched_status_t;

endpackage

// File: rtl/ovc_credit_scheduler_rr_arb.sv
// ovc_sched_rr_arb
// V-input one-hot round-robin arbiter. The pointer names the highest
// priority input; the search wraps around from there. Pointer updates are
// the parent's job.
//   req   : request mask
//   ptr   : index of highest-priority input
//   grant : one-hot grant, zero when no request
module ovc_sched_rr_arb #(
  parameter int V  = 4,
  parameter int PW = (V > 1) ? $clog2(V) : 1
) (
  input  logic [V-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [V-1:0]  grant
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < V; i++) begin
      idx = PW'((int'(ptr) + i) % V);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ovc_credit_scheduler.sv
// ovc_credit_scheduler
// Credit-based output-VC scheduler for one router output port. One credit
// counter per VC, packet-level round-robin, link locked header-to-tail.
// Optional build macro: OVC_SCHED_HETERO_EN (neighbour VC presence mask
// sampled during reset; absent VCs hold zero credit and are never granted).
//
// Ports
//   clk, reset             : clock, synchronous active-low reset
//   req_i/hdr_i/tail_i     : per-VC ready flit and its header/tail flags
//   credit_in_i            : one credit returned per VC
//   credit_init_val_i      : per-VC initial credit, loaded while reset is low
//   hetero_ovc_presence_i  : neighbour VC exists (macro builds only)
//   grant_o                : combinational one-hot grant
//   flit_wr_o / vc_o       : registered copy of the previous cycle's grant
//   ovc_avail_o            : VC has nonzero credit
//   credit_cnt_o           : packed credit counters
//   locked_o               : link locked mid-packet
//   err_o                  : sticky protocol / overflow error
//
// state       | meaning
// OSCH_IDLE   | any eligible VC may win; header-only flits may start packets
// OSCH_LOCKED | link owned by lock_q until its tail flit is granted
module ovc_credit_scheduler
  import ovc_credit_scheduler_pkg::*;
#(
  parameter int V  = OVC_V,
  parameter int B  = OVC_B,
  parameter int CW = $clog2(B + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [V-1:0]    req_i,
  input  logic [V-1:0]    hdr_i,
  input  logic [V-1:0]    tail_i,
  input  logic [V-1:0]    credit_in_i,
  input  logic [V*CW-1:0] credit_init_val_i,
  input  logic [V-1:0]    hetero_ovc_presence_i,
  output logic [V-1:0]    grant_o,
  output logic            flit_wr_o,
  output logic [V-1:0]    vc_o,
  output logic [V-1:0]    ovc_avail_o,
  output logic [V*CW-1:0] credit_cnt_o,
  output logic            locked_o,
  output logic            err_o
);

  localparam int            PW   = (V > 1) ? $clog2(V) : 1;
  localparam logic [CW-1:0] BMAX = CW'(B);

  ovc_sched_state_t state_q;
  logic [CW-1:0]    cnt_q [V];
  logic [V-1:0]     lock_q;
  logic [PW-1:0]    ptr_q;
  logic             err_q;
  logic             flit_wr_q;
  logic [V-1:0]     vc_q;

  logic [V-1:0] present;
  logic [V-1:0] present_in;
  logic [V-1:0] has_credit;
  logic [V-1:0] elig;
  logic [V-1:0] arb_grant;
  logic [V-1:0] grant;
  logic [V-1:0] ovf;
  logic         proto_err;
  logic         grant_hdr;
  logic         grant_tail;

`ifdef OVC_SCHED_HETERO_EN
  logic [V-1:0] present_q;

  always_ff @(posedge clk) begin
    if (!reset) present_q <= hetero_ovc_presence_i;
  end

  assign present_in = hetero_ovc_presence_i;
  assign present    = present_q;
`else
  logic unused_presence;

  assign unused_presence = ^hetero_ovc_presence_i;
  assign present_in      = '1;
  assign present         = '1;
`endif

  function automatic logic [CW-1:0] clamp_credit(input logic [CW-1:0] val);
    return (val > BMAX) ? BMAX : val;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [V-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < V; i++) begin
      if (oh[i]) idx = i;
    end
    return PW'((idx + 1) % V);
  endfunction

  always_comb begin
    has_credit = '0;
    for (int v = 0; v < V; v++) begin
      has_credit[v] = present[v] && (cnt_q[v] != '0);
    end
  end

  assign elig = req_i & has_credit;

  ovc_sched_rr_arb #(.V(V), .PW(PW)) u_arb (
    .req   (elig),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  // In IDLE only a header may open the link; a non-header winner is a
  // protocol error and nobody is granted. In LOCKED a header on the owner
  // means it started a new packet without finishing the old one.
  always_comb begin
    grant     = '0;
    proto_err = 1'b0;
    if (reset) begin
      if (state_q == OSCH_IDLE) begin
        if ((arb_grant & hdr_i) != '0) grant = arb_grant;
        else if (arb_grant != '0)      proto_err = 1'b1;
      end else begin
        if ((lock_q & req_i & hdr_i) != '0) proto_err = 1'b1;
        else                                grant = lock_q & elig;
      end
    end
  end

  assign grant_hdr  = |(grant & hdr_i);
  assign grant_tail = |(grant & tail_i);

  // A credit into a full counter is dropped unless the same VC is granted
  // in this cycle; a credit for an absent VC is always an error.
  always_comb begin
    ovf = '0;
    for (int v = 0; v < V; v++) begin
      ovf[v] = credit_in_i[v] && (!present[v] || (!grant[v] && cnt_q[v] >= BMAX));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= OSCH_IDLE;
      lock_q    <= '0;
      ptr_q     <= '0;
      err_q     <= 1'b0;
      flit_wr_q <= 1'b0;
      vc_q      <= '0;
      for (int v = 0; v < V; v++) begin
        cnt_q[v] <= present_in[v] ? clamp_credit(credit_init_val_i[v*CW +: CW]) : '0;
      end
    end else begin
      for (int v = 0; v < V; v++) begin
        if (!present[v])
          cnt_q[v] <= '0;
        else if (ovf[v])
          cnt_q[v] <= BMAX;
        else
          cnt_q[v] <= cnt_q[v] - CW'(grant[v]) + CW'(credit_in_i[v]);
      end

      if (proto_err || (ovf != '0)) err_q <= 1'b1;

      flit_wr_q <= |grant;
      vc_q      <= grant;

      if (grant_tail) ptr_q <= next_ptr(grant);

      case (state_q)
        OSCH_IDLE: begin
          if (grant_hdr && !grant_tail) begin
            state_q <= OSCH_LOCKED;
            lock_q  <= grant;
          end
        end
        OSCH_LOCKED: begin
          if (grant_tail) begin
            state_q <= OSCH_IDLE;
            lock_q  <= '0;
          end
        end
        default: begin
          state_q <= OSCH_IDLE;
          lock_q  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    ovc_avail_o  = '0;
    credit_cnt_o = '0;
    for (int v = 0; v < V; v++) begin
      ovc_avail_o[v]           = cnt_q[v] != '0;
      credit_cnt_o[v*CW +: CW] = cnt_q[v];
    end
  end

  assign grant_o   = grant;
  assign flit_wr_o = flit_wr_q;
  assign vc_o      = vc_q;
  assign locked_o  = (state_q == OSCH_LOCKED);
  assign err_o     = err_q;

endmodule

// File: tb/tb_ovc_credit_scheduler.sv
module tb_ovc_credit_scheduler;

  localparam int NV = 4;
  localparam int B  = 4;
  localparam int CW = 3;

  logic            clk;
  logic            rst;
  logic [NV-1:0]   req, hdr, tail, crd, pres;
  logic [NV*CW-1:0] init_v;
  logic [NV-1:0]   grant_o, vc_o, ovc_avail_o;
  logic            flit_wr_o, locked_o, err_o;
  logic [NV*CW-1:0] credit_cnt_o;

  ovc_credit_scheduler dut (
    .clk                   (clk),
    .reset                 (rst),
    .req_i                 (req),
    .hdr_i                 (hdr),
    .tail_i                (tail),
    .credit_in_i           (crd),
    .credit_init_val_i     (init_v),
    .hetero_ovc_presence_i (pres),
    .grant_o               (grant_o),
    .flit_wr_o             (flit_wr_o),
    .vc_o                  (vc_o),
    .ovc_avail_o           (ovc_avail_o),
    .credit_cnt_o          (credit_cnt_o),
    .locked_o              (locked_o),
    .err_o                 (err_o)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // reference model: plain integers and flags
  int m_cred [NV];
  bit m_pres [NV];
  bit m_locked;
  int m_lv;
  int m_ptr;
  bit m_err;
  int last_g;
  logic [NV-1:0] obs_g;

  int pk_left  [NV];
  bit pk_first [NV];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_pick(output int g, output bit perr);
    g = -1;
    perr = 0;
    if (!m_locked) begin
      for (int k = 0; k < NV; k++) begin
        int v;
        v = (m_ptr + k) % NV;
        if (req[v] && m_cred[v] > 0) begin
          if (hdr[v]) g = v;
          else        perr = 1;
          break;
        end
      end
    end else if (req[m_lv] && hdr[m_lv]) begin
      perr = 1;
    end else if (req[m_lv] && m_cred[m_lv] > 0) begin
      g = m_lv;
    end
  endfunction

  function automatic void model_update(input int g, input bit perr);
    for (int v = 0; v < NV; v++) begin
      if (crd[v]) begin
        if (!m_pres[v])                  m_err = 1;
        else if (m_cred[v] == B && g != v) m_err = 1;
        else                             m_cred[v]++;
      end
    end
    if (perr) m_err = 1;
    if (g >= 0) begin
      m_cred[g]--;
      if (!m_locked && hdr[g] && !tail[g]) begin
        m_locked = 1;
        m_lv = g;
      end else if (m_locked && tail[g]) begin
        m_locked = 0;
      end
      if (tail[g]) m_ptr = (g + 1) % NV;
    end
  endfunction

  function automatic logic [31:0] exp_cnt();
    logic [31:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v*CW +: CW] = 3'(m_cred[v]);
    return r;
  endfunction

  function automatic logic [31:0] exp_avail();
    logic [31:0] r;
    r = '0;
    for (int v = 0; v < NV; v++) r[v] = m_cred[v] != 0;
    return r;
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_cnt"}, 32'(credit_cnt_o), exp_cnt());
    chk({tag, "_avail"}, 32'(ovc_avail_o), exp_avail());
    chk({tag, "_locked"}, 32'(locked_o), 32'(m_locked));
    chk({tag, "_err"}, 32'(err_o), 32'(m_err));
  endtask

  // inputs were driven at posedge+1; grant checked at posedge+2,
  // registered outputs at the next posedge+1
  task automatic step();
    int g;
    bit perr;
    #1;
    model_pick(g, perr);
    obs_g = grant_o;
    chk("grant", 32'(grant_o), (g >= 0) ? (32'd1 << g) : 32'd0);
    @(posedge clk);
    #1;
    model_update(g, perr);
    chk("flit_wr", 32'(flit_wr_o), 32'(g >= 0));
    chk("vc", 32'(vc_o), (g >= 0) ? (32'd1 << g) : 32'd0);
    check_state("step");
    last_g = g;
  endtask

  task automatic do_reset(input logic [NV*CW-1:0] init, input logic [NV-1:0] p);
    rst = 0;
    init_v = init;
    pres = p;
    #1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_flit_wr", 32'(flit_wr_o), 32'd0);
    chk("rst_locked", 32'(locked_o), 32'd0);
    @(posedge clk);
    #1;
    for (int v = 0; v < NV; v++) begin
`ifdef OVC_SCHED_HETERO_EN
      m_pres[v] = p[v];
`else
      m_pres[v] = 1;
`endif
      m_cred[v] = m_pres[v] ? ((int'(init[v*CW +: CW]) > B) ? B : int'(init[v*CW +: CW])) : 0;
    end
    m_locked = 0;
    m_lv = 0;
    m_ptr = 0;
    m_err = 0;
    chk("rst_vc", 32'(vc_o), 32'd0);
    check_state("rst");
    rst = 1;
  endtask

  task automatic idle_inputs();
    req = '0; hdr = '0; tail = '0; crd = '0;
  endtask

  localparam logic [NV*CW-1:0] INIT4 = {3'd4, 3'd4, 3'd4, 3'd4};

  initial begin
    logic [NV-1:0] order [5];
    clk = 0; rst = 0;
    idle_inputs();
    pres = '1;
    init_v = INIT4;
    last_g = -1;

    // single-flit packets on VC0 drain its credits
    do_reset(INIT4, '1);
    req = 4'b0001; hdr = 4'b0001; tail = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t1_grant", 32'(obs_g), (k < 4) ? 32'd1 : 32'd0);
    end
    chk("t1_cnt0", 32'(credit_cnt_o[2:0]), 32'd0);
    chk("t1_avail", 32'(ovc_avail_o), 32'b1110);

    // round-robin over all VCs with credits returned right away
    idle_inputs();
    do_reset(INIT4, '1);
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
    order[3] = 4'b1000; order[4] = 4'b0001;
    req = '1; hdr = '1; tail = '1;
    for (int k = 0; k < 5; k++) begin
      crd = (last_g >= 0 && k > 0) ? 4'(1 << last_g) : 4'b0;
      step();
      chk("t2_order", 32'(obs_g), 32'(order[k]));
    end

    // VC1 three-flit packet holds the link against VC2
    idle_inputs();
    do_reset(INIT4, '1);
    for (int k = 0; k < 4; k++) begin
      req  = {1'b0, 1'b1, (k < 3), 1'b0};
      hdr  = {1'b0, 1'b1, (k == 0), 1'b0};
      tail = {1'b0, 1'b1, (k == 2), 1'b0};
      step();
      chk("t3_grant", 32'(obs_g), (k < 3) ? 32'b0010 : 32'b0100);
      chk("t3_locked", 32'(locked_o), 32'(k < 2));
    end

    // VC1 locked with no credit: bubbles until a credit comes back
    idle_inputs();
    do_reset({3'd4, 3'd4, 3'd1, 3'd4}, '1);
    for (int k = 0; k < 6; k++) begin
      req  = {1'b0, 1'b1, (k < 5), 1'b0};
      hdr  = {1'b0, 1'b1, (k == 0), 1'b0};
      tail = {1'b0, 1'b1, (k >= 1), 1'b0};
      crd  = (k == 3) ? 4'b0010 : 4'b0000;
      step();
      if (k == 0)      chk("t4_hdr", 32'(obs_g), 32'b0010);
      else if (k < 4)  chk("t4_bubble", 32'(obs_g), 32'd0);
      else if (k == 4) chk("t4_resume", 32'(obs_g), 32'b0010);
      else             chk("t4_vc2", 32'(obs_g), 32'b0100);
    end

    // credit overflow, grant+credit in the same cycle, protocol error
    idle_inputs();
    do_reset(INIT4, '1);
    crd = 4'b0001;
    step();
    chk("ovf_cnt0", 32'(credit_cnt_o[2:0]), 32'd4);
    chk("ovf_err", 32'(err_o), 32'd1);
    crd = '0;
    step();
    step();
    chk("ovf_sticky", 32'(err_o), 32'd1);
    do_reset(INIT4, '1);
    chk("ovf_clr", 32'(err_o), 32'd0);
    req = 4'b0001; hdr = 4'b0001; tail = 4'b0001; crd = 4'b0001;
    step();
    chk("gc_cnt0", 32'(credit_cnt_o[2:0]), 32'd4);
    chk("gc_err", 32'(err_o), 32'd0);
    req = 4'b0001; hdr = 4'b0000; tail = 4'b0000; crd = '0;
    step();
    chk("perr_grant", 32'(obs_g), 32'd0);
    chk("perr_err", 32'(err_o), 32'd1);

    // init above B is clamped
    idle_inputs();
    do_reset({3'd7, 3'd5, 3'd2, 3'd0}, '1);
    chk("clamp_cnt", 32'(credit_cnt_o), 32'({3'd4, 3'd4, 3'd2, 3'd0}));

    // reset asserted mid-packet abandons the lock
    idle_inputs();
    do_reset({3'd4, 3'd4, 3'd3, 3'd4}, '1);
    req = 4'b0010; hdr = 4'b0010; tail = 4'b0000;
    step();
    hdr = 4'b0000;
    step();
    chk("mid_locked", 32'(locked_o), 32'd1);
    chk("mid_cnt1", 32'(credit_cnt_o[5:3]), 32'd1);
    do_reset(INIT4, '1);
    chk("mid_reload", 32'(credit_cnt_o), 32'(INIT4));

`ifdef OVC_SCHED_HETERO_EN
    idle_inputs();
    do_reset(INIT4, 4'b0011);
    req = '1; hdr = '1; tail = '1;
    for (int k = 0; k < 8; k++) begin
      crd = (last_g >= 0 && k > 0) ? 4'(1 << last_g) : 4'b0;
      step();
      chk("het_nogrant", 32'(obs_g & 4'b1100), 32'd0);
    end
    chk("het_cnt", 32'(credit_cnt_o[11:6]), 32'd0);
`endif

    // randomized legal traffic
    idle_inputs();
    begin
      logic [NV*CW-1:0] ri;
      for (int v = 0; v < NV; v++) ri[v*CW +: CW] = 3'($urandom_range(0, 7));
      do_reset(ri, '1);
    end
    for (int v = 0; v < NV; v++) begin
      pk_left[v] = 0;
      pk_first[v] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int v = 0; v < NV; v++) begin
        if (pk_left[v] == 0 && $urandom_range(0, 2) == 0) begin
          pk_left[v] = $urandom_range(1, 4);
          pk_first[v] = 1;
        end
        req[v]  = pk_left[v] > 0;
        hdr[v]  = pk_first[v] && pk_left[v] > 0;
        tail[v] = pk_left[v] == 1;
        crd[v]  = m_pres[v] && (m_cred[v] < B) && ($urandom_range(0, 1) == 1);
      end
      step();
      if (last_g >= 0) begin
        pk_left[last_g]--;
        pk_first[last_g] = 0;
      end
    end
    chk("rand_err", 32'(err_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
